imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 113 +++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader FSM state encoding and stream framing sizes.
package loader_pkg;

   typedef enum logic [2:0] {
      HDR_LO,
      HDR_HI,
      DATA,
      HOLD,
      RUN,
      ERR
   } loader_state_t;

   localparam int WORD_BYTES = 4;
   localparam int HDR_BYTES  = 2;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words.
// Ports: clk, rst, byte_valid/byte_data in; word_valid/word out (same cycle as 4th byte).
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int IDX_W = $clog2(WORD_BYTES);

   logic [IDX_W-1:0] idx;
   logic [23:0]      low;

   // Bytes shift in from the top, so after three bytes the first one
   // sits in bits 7:0 and the fourth byte completes the word.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
         low <= '0;
      end else if (byte_valid) begin
         idx <= idx + 1'b1;
         low <= {byte_data, low[23:8]};
      end
   end

   assign word_valid = byte_valid && (idx == IDX_W'(WORD_BYTES - 1));
   assign word       = {byte_data, low};

endmodule

// File: rtl/imem_loader.sv
// Program loader: byte stream -> instruction memory writes, then core release.
// Ports: s_valid/s_ready/s_data in; imem_we/addr/wdata, core_rst, done, err, words_loaded out.
module imem_loader
   import loader_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = $clog2(DEPTH),
   parameter int HOLD_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

   loader_state_t    state;
   loader_state_t    state_nx;
   logic [7:0]       n_lo;
   logic [15:0]      n_words;
   logic [15:0]      hdr_n;
   logic [CNT_W-1:0] hold_cnt;
   logic             accept;
   logic             word_valid;
   logic [31:0]      word;
   logic             last_word;

   assign s_ready = !rst && (state inside {HDR_LO, HDR_HI, DATA});
   assign accept  = s_valid && s_ready;
   assign hdr_n   = {s_data, n_lo};

   // True while the word being completed is index N-1.
   assign last_word = (17'(words_loaded) + 17'd1) == {1'b0, n_words};

   word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .byte_valid (accept && (state == DATA)),
      .byte_data  (s_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= HDR_LO;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      core_rst = 1'b1;
      done     = 1'b0;
      err      = 1'b0;
      unique case (state)
         HDR_LO: if (accept) state_nx = HDR_HI;
         HDR_HI: begin
            if (accept) begin
               if (hdr_n == 16'd0)
                  state_nx = HOLD;
               else if ({1'b0, hdr_n} > 17'(DEPTH))
                  state_nx = ERR;
               else
                  state_nx = DATA;
            end
         end
         DATA: if (word_valid && last_word) state_nx = HOLD;
         HOLD: begin
            if (hold_cnt == CNT_W'(HOLD_CYCLES - 1))
               state_nx = RUN;
         end
         RUN: begin
            core_rst = 1'b0;
            done     = 1'b1;
         end
         ERR: err = 1'b1;
         default: state_nx = HDR_LO;
      endcase
   end

   // The write pulse is registered one cycle after the 4th byte; the
   // hold timer counts from the first HOLD cycle, which is that pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_lo         <= '0;
         n_words      <= '0;
         hold_cnt     <= '0;
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
      end else begin
         imem_we <= word_valid;
         if (accept && (state == HDR_LO)) n_lo <= s_data;
         if (accept && (state == HDR_HI)) n_words <= hdr_n;
         if (word_valid) begin
            imem_addr    <= words_loaded[ADDR_W-1:0];
            imem_wdata   <= word;
            words_loaded <= words_loaded + 1'b1;
         end
         hold_cnt <= (state == HOLD) ? hold_cnt + 1'b1 : '0;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader.
// Queue-based reference model of expected writes and release timing.
module tb_imem_loader;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;
   localparam int HOLD   = 4;

   typedef logic [7:0] bq_t[$];

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [7:0]        s_data = '0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_wr = 0;
   int last_hs = 0;
   logic prev_we = 1'b0;

   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [31:0] prog[$];

   imem_loader #(
      .DEPTH       (DEPTH),
      .ADDR_W      (ADDR_W),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .imem_we      (imem_we),
      .imem_addr    (imem_addr),
      .imem_wdata   (imem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .err          (err),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // Write monitor: every pulse must match the head of the model queue.
   always @(negedge clk) begin
      if (imem_we) begin
         n_wr++;
         chk("we_pulse", {31'd0, prev_we}, 32'd0);
         if (exp_addr.size() == 0) begin
            chk("spurious_we", 32'd1, 32'd0);
         end else begin
            chk("we_addr", {22'd0, imem_addr}, exp_addr.pop_front());
            chk("we_data", imem_wdata, exp_data.pop_front());
         end
         chk("we_wl", {21'd0, words_loaded}, n_wr);
      end
      prev_we = imem_we;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_addr = {};
      exp_data = {};
      n_wr = 0;
   endtask

   task automatic send(input bq_t q, input int gap);
      int i = 0;
      int stall = 0;
      logic r1;
      while (i < q.size()) begin
         @(negedge clk);
         if (gap > 0 && $urandom_range(99) < gap) begin
            s_valid = 1'b0;
            s_data = 8'($urandom);
         end else begin
            s_valid = 1'b1;
            s_data = q[i];
         end
         #1;
         r1 = s_ready;
         s_valid = ~s_valid;
         #1;
         chk("rdy_indep", {31'd0, s_ready}, {31'd0, r1});
         s_valid = ~s_valid;
         if (s_valid && s_ready) begin
            i++;
            last_hs = cyc;
            stall = 0;
         end else if (++stall > 1000) begin
            chk("stall_to", 32'd1, 32'd0);
            s_valid = 1'b0;
            return;
         end
      end
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic wait_done(input int t_ref);
      int k = 0;
      while (!done && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("done_cyc", cyc, t_ref + HOLD);
      chk("core_rst_lo", {31'd0, core_rst}, 32'd0);
   endtask

   // Builds the byte stream from prog, queues the expected writes and
   // checks the write sequence and release timing.
   task automatic load(input int n, input int gap);
      bq_t q;
      logic [31:0] w;
      q = {};
      q.push_back(n[7:0]);
      q.push_back(n[15:8]);
      for (int i = 0; i < n; i++) begin
         w = prog[i];
         exp_addr.push_back(i);
         exp_data.push_back(w);
         for (int b = 0; b < 4; b++) q.push_back(w[8*b +: 8]);
      end
      send(q, gap);
      wait_done(last_hs + 1);
      chk("wl_final", {21'd0, words_loaded}, n);
      chk("n_writes", n_wr, n);
      chk("err_lo", {31'd0, err}, 32'd0);
      chk("exp_drain", exp_addr.size(), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      bq_t q;
      int n;

      // Reset state
      s_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, s_ready}, 32'd0);
      chk("rst_core", {31'd0, core_rst}, 32'd1);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_we", {31'd0, imem_we}, 32'd0);
      chk("rst_addr", {22'd0, imem_addr}, 32'd0);
      chk("rst_wdata", imem_wdata, 32'd0);
      chk("rst_wl", {21'd0, words_loaded}, 32'd0);
      s_valid = 1'b0;
      rst = 1'b0;

      // Basic load, continuous stream
      prog = {32'h0000_0013, 32'h0050_0093};
      load(2, 0);

      // Same program under backpressure
      do_reset();
      load(2, 50);

      // Random programs with random gaps
      for (int t = 0; t < 5; t++) begin
         do_reset();
         n = $urandom_range(1, 8);
         prog = {};
         for (int i = 0; i < n; i++) prog.push_back($urandom);
         load(n, $urandom_range(0, 60));
      end

      // Empty program
      do_reset();
      prog = {};
      load(0, 30);
      s_valid = 1'b1;
      s_data = 8'hAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("run_ready", {31'd0, s_ready}, 32'd0);
      end
      s_valid = 1'b0;
      chk("run_nowr", n_wr, 32'd0);
      chk("run_done", {31'd0, done}, 32'd1);

      // Oversize header
      do_reset();
      q = {8'h01, 8'h04};
      send(q, 20);
      s_valid = 1'b1;
      repeat (10) @(negedge clk);
      chk("ovr_err", {31'd0, err}, 32'd1);
      chk("ovr_ready", {31'd0, s_ready}, 32'd0);
      chk("ovr_core", {31'd0, core_rst}, 32'd1);
      chk("ovr_done", {31'd0, done}, 32'd0);
      chk("ovr_nowr", n_wr, 32'd0);
      do_reset();
      chk("ovr_clr", {31'd0, err}, 32'd0);
      prog = {32'hCAFE_F00D};
      load(1, 20);

      // Reset in the middle of the second word
      do_reset();
      prog = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
      exp_addr.push_back(0);
      exp_data.push_back(prog[0]);
      q = {8'h03, 8'h00, 8'h22, 8'h22, 8'h11, 8'h11, 8'h44};
      send(q, 30);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_nwr", n_wr, 32'd1);
      chk("mid_core", {31'd0, core_rst}, 32'd1);
      chk("mid_wl", {21'd0, words_loaded}, 32'd0);
      chk("mid_we", {31'd0, imem_we}, 32'd0);
      chk("mid_addr", {22'd0, imem_addr}, 32'd0);
      chk("mid_wdata", imem_wdata, 32'd0);
      chk("mid_ready", {31'd0, s_ready}, 32'd0);
      do_reset();
      prog = {32'hDEAD_BEEF};
      load(1, 0);

      // Full depth
      do_reset();
      prog = {};
      for (int i = 0; i < DEPTH; i++) prog.push_back(i * 32'h0101_0101 + 32'h5A);
      load(DEPTH, 0);
      chk("full_addr", {22'd0, imem_addr}, DEPTH - 1);
      chk("full_data", imem_wdata, (DEPTH - 1) * 32'h0101_0101 + 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
